// File: rtl/sfifo_sp_ctrl_if.sv
// Stream-side bundle of the single-port FIFO controller.
// slave modport: the controller; master modport: producer/consumer.
interface sfifo_sp_ctrl_if #(
    parameter int BW     = 48,
    parameter int LGFLEN = 8
);
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              o_full;
    logic              i_rd;
    logic [BW-1:0]     o_data;
    logic              o_empty;
    logic [LGFLEN+1:0] o_fill;

    modport master (
        output i_wr, i_data, i_rd,
        input  o_full, o_data, o_empty, o_fill
    );

    modport slave (
        input  i_wr, i_data, i_rd,
        output o_full, o_data, o_empty, o_fill
    );
endinterface

// File: rtl/sfifo_sp_ctrl.sv
// Synchronous FIFO controller for a single-port SRAM (one memory op per cycle).
// 1-entry write buffer in front of memory, 2-entry first-word-fall-through
// output buffer behind it. Writes and prefetch reads share the port via a
// round-robin arbiter that only advances on contested cycles.
// Optional macro SFIFO_SP_BYPASS_EN: when memory is empty and nothing is in
// flight, the write buffer moves straight into the output buffer.
module sfifo_sp_ctrl #(
    parameter int BW     = 48,
    parameter int LGFLEN = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    sfifo_sp_ctrl_if.slave    s,
    output logic              o_mem_wr,
    output logic [LGFLEN-1:0] o_mem_wr_addr,
    output logic [BW-1:0]     o_mem_data,
    output logic              o_mem_rd,
    output logic [LGFLEN-1:0] o_mem_rd_addr,
    input  logic [BW-1:0]     i_mem_data
);
    localparam int unsigned DEPTH = 1 << LGFLEN;

    typedef enum logic {PRI_RD, PRI_WR} pri_t;

    logic [LGFLEN-1:0]       wr_ptr, rd_ptr;
    logic [LGFLEN:0]         mem_cnt;
    logic                    wb_valid;
    logic [BW-1:0]           wb_data;
    logic [1:0][BW-1:0]      ob, ob_n;
    logic [1:0]              ob_cnt, ob_cnt_n;
    logic                    inflight;
    pri_t                    pri;

    logic bypass, wr_req, rd_req, wr_gnt, rd_gnt, wb_drain;
    logic push, pop, append;
    logic [BW-1:0] app_data;

    // Arbitration and handshake decode from registered state only
    always_comb begin
        bypass = 1'b0;
`ifdef SFIFO_SP_BYPASS_EN
        bypass = wb_valid && (mem_cnt == '0) && !inflight && (ob_cnt != 2'd2);
`endif
        wr_req   = wb_valid && (mem_cnt != (LGFLEN+1)'(DEPTH)) && !bypass;
        rd_req   = (mem_cnt != '0) && ((ob_cnt + {1'b0, inflight}) < 2'd2);
        wr_gnt   = wr_req && (!rd_req || pri == PRI_WR);
        rd_gnt   = rd_req && (!wr_req || pri == PRI_RD);
        wb_drain = wr_gnt || bypass;
        push     = s.i_wr && !(wb_valid && !wb_drain);
        pop      = s.i_rd && (ob_cnt != 2'd0);
        append   = inflight || bypass;
        app_data = inflight ? i_mem_data : wb_data;
    end

    // Output buffer next state: pop shifts down, append fills the first free slot
    always_comb begin
        ob_n     = ob;
        ob_cnt_n = ob_cnt;
        if (pop) begin
            ob_n[0]  = ob[1];
            ob_cnt_n = ob_cnt - 2'd1;
        end
        if (append) begin
            ob_n[ob_cnt_n[0]] = app_data;
            ob_cnt_n          = ob_cnt_n + 2'd1;
        end
    end

    // Stream and memory-side outputs
    always_comb begin
        s.o_full      = wb_valid && !wb_drain;
        s.o_empty     = (ob_cnt == 2'd0);
        s.o_data      = ob[0];
        s.o_fill      = (LGFLEN+2)'(wb_valid) + (LGFLEN+2)'(mem_cnt)
                      + (LGFLEN+2)'(inflight) + (LGFLEN+2)'(ob_cnt);
        o_mem_wr      = wr_gnt && !i_reset;
        o_mem_rd      = rd_gnt && !i_reset;
        o_mem_wr_addr = wr_ptr;
        o_mem_rd_addr = rd_ptr;
        o_mem_data    = wb_data;
    end

    // Pointer, count, buffer and arbiter state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            ob       <= '0;
            ob_cnt   <= '0;
            inflight <= 1'b0;
            pri      <= PRI_RD;
        end else begin
            if (wr_gnt) begin
                wr_ptr  <= wr_ptr + 1'b1;
                mem_cnt <= mem_cnt + 1'b1;
            end else if (rd_gnt) begin
                rd_ptr  <= rd_ptr + 1'b1;
                mem_cnt <= mem_cnt - 1'b1;
            end
            if (push) begin
                wb_valid <= 1'b1;
                wb_data  <= s.i_data;
            end else if (wb_drain) begin
                wb_valid <= 1'b0;
            end
            ob       <= ob_n;
            ob_cnt   <= ob_cnt_n;
            inflight <= rd_gnt;
            if (wr_req && rd_req)
                pri <= wr_gnt ? PRI_RD : PRI_WR;
        end
    end
endmodule

// File: tb/tb_sfifo_sp_ctrl.sv
// Self-checking bench for sfifo_sp_ctrl with a behavioural single-port memory.
// Scoreboard: accepted pushes enter a queue; the monitor pops and compares on
// every honoured pop and tracks the expected fill count.
module tb_sfifo_sp_ctrl;
    localparam int BW     = 48;
    localparam int LGFLEN = 8;
    localparam int CAP    = (1 << LGFLEN) + 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_wr, mem_rd;
    logic [LGFLEN-1:0] mem_wr_addr, mem_rd_addr;
    logic [BW-1:0]     mem_wdata, mem_rdata;
    logic [BW-1:0]     mem [1 << LGFLEN];

    sfifo_sp_ctrl_if #(.BW(BW), .LGFLEN(LGFLEN)) ifc ();

    sfifo_sp_ctrl #(.BW(BW), .LGFLEN(LGFLEN)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .s            (ifc.slave),
        .o_mem_wr     (mem_wr),
        .o_mem_wr_addr(mem_wr_addr),
        .o_mem_data   (mem_wdata),
        .o_mem_rd     (mem_rd),
        .o_mem_rd_addr(mem_rd_addr),
        .i_mem_data   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port SRAM model: read data valid the cycle after the strobe
    always @(posedge clk) begin
        if (mem_wr) mem[mem_wr_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_rd_addr];
    end

    int          checks = 0;
    int          errors = 0;
    int          model_fill = 0;
    int          pushed_total = 0;
    int          wr_grants = 0;
    logic [BW-1:0] sb_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: sample away from the active edge, log handshakes, compare pops
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            model_fill = 0;
        end else begin
            chk("fill_track", 64'(ifc.o_fill), 64'(model_fill));
            chk("mem_excl", 64'(mem_wr && mem_rd), 64'd0);
            if (mem_wr) wr_grants++;
            if (ifc.i_rd && !ifc.o_empty) begin
                if (sb_q.size() == 0) begin
                    chk("pop_unexpected", 64'(ifc.o_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("pop_data", 64'(ifc.o_data), 64'(sb_q.pop_front()));
                    model_fill--;
                end
            end
            if (ifc.i_wr && !ifc.o_full) begin
                sb_q.push_back(ifc.i_data);
                model_fill++;
                pushed_total++;
            end
        end
    end

    task automatic cyc(input logic wr, input logic [BW-1:0] d, input logic rd);
        ifc.i_wr   = wr;
        ifc.i_data = d;
        ifc.i_rd   = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (model_fill != 0 && n < 2000) begin
            cyc(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_done", 64'(model_fill), 64'd0);
    endtask

    initial begin
        int n;
        int base;
        int wg0;
        ifc.i_wr = 1'b0; ifc.i_rd = 1'b0; ifc.i_data = '0;
        rst = 1'b1;
        repeat (3) cyc(1'b0, '0, 1'b0);
        chk("rst_mem_wr_low", 64'(mem_wr), 64'd0);
        rst = 1'b0;
        chk("rst_empty", 64'(ifc.o_empty), 64'd1);
        chk("rst_full", 64'(ifc.o_full), 64'd0);
        chk("rst_fill", 64'(ifc.o_fill), 64'd0);
        chk("rst_data", 64'(ifc.o_data), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);

        // 1: single push latency
        cyc(1'b1, 48'hA5, 1'b0);                 // edge k
        chk("lat_k", 64'(ifc.o_empty), 64'd1);
        cyc(1'b0, '0, 1'b0);                     // edge k+1
`ifdef SFIFO_SP_BYPASS_EN
        chk("lat_k1", 64'(ifc.o_empty), 64'd0);
`else
        chk("lat_k1", 64'(ifc.o_empty), 64'd1);
        cyc(1'b0, '0, 1'b0);                     // edge k+2
        chk("lat_k2", 64'(ifc.o_empty), 64'd1);
        cyc(1'b0, '0, 1'b0);                     // edge k+3
`endif
        chk("lat_empty", 64'(ifc.o_empty), 64'd0);
        chk("lat_data", 64'(ifc.o_data), 64'hA5);
        chk("lat_fill", 64'(ifc.o_fill), 64'd1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);

        // 2: fill to capacity, then one ignored push
        base = pushed_total;
        n = 0;
        while (pushed_total - base < CAP && n < 2000) begin
            cyc(1'b1, 48'(pushed_total - base), 1'b0);
            n++;
        end
        repeat (4) cyc(1'b0, '0, 1'b0);
        chk("full_count", 64'(pushed_total - base), 64'(CAP));
        chk("full_flag", 64'(ifc.o_full), 64'd1);
        chk("full_fill", 64'(ifc.o_fill), 64'(CAP));
        cyc(1'b1, 48'h999, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("full_ignore", 64'(ifc.o_fill), 64'(CAP));

        // 3: push and pop every cycle from full
        wg0 = wr_grants;
        for (int i = 0; i < 200; i++)
            cyc(1'b1, 48'(pushed_total - base), 1'b1);
        checks++;
        if (wr_grants - wg0 < 96) begin
            errors++;
            $display("FAIL rr_wr_grants actual=%0d required>=%0d", wr_grants - wg0, 96);
        end
        drain();

        // 4: random traffic with 1000 incrementing words
        base = pushed_total;
        n = 0;
        while (pushed_total - base < 1000 && n < 30000) begin
            cyc(1'($urandom_range(0, 1)), 48'(pushed_total - base), 1'($urandom_range(0, 1)));
            n++;
        end
        chk("rand_count", 64'(pushed_total - base), 64'd1000);
        drain();

        // 5: pop on empty; simultaneous pop+push at fill 1
        repeat (3) cyc(1'b0, '0, 1'b1);
        chk("pop_empty_fill", 64'(ifc.o_fill), 64'd0);
        chk("pop_empty_flag", 64'(ifc.o_empty), 64'd1);
        cyc(1'b1, 48'h1234, 1'b0);
        n = 0;
        while (ifc.o_empty && n < 10) begin
            cyc(1'b0, '0, 1'b0);
            n++;
        end
        chk("f1_ready", 64'(ifc.o_empty), 64'd0);
        cyc(1'b1, 48'h5678, 1'b1);
        cyc(1'b0, '0, 1'b0);
        chk("f1_fill", 64'(ifc.o_fill), 64'd1);
        drain();

        // 6: reset with a memory read in flight
        for (int i = 0; i < 4; i++) cyc(1'b1, 48'(100 + i), 1'b0);
        repeat (4) cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        n = 0;
        while (!mem_rd && n < 20) begin
            cyc(1'b0, '0, 1'b0);
            n++;
        end
        chk("rd_seen", 64'(mem_rd), 64'd1);
        cyc(1'b0, '0, 1'b0);                     // read edge
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);                     // reset edge, data returning
        rst = 1'b0;
        chk("rstf_empty", 64'(ifc.o_empty), 64'd1);
        chk("rstf_fill", 64'(ifc.o_fill), 64'd0);
        cyc(1'b0, '0, 1'b0);
        chk("rstf_drop", 64'(ifc.o_empty), 64'd1);
        chk("rstf_fill2", 64'(ifc.o_fill), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
